// File: rtl/jtframe_sdram_arb.sv
// N-channel arbiter in front of one SDRAM bank port (clk_rom domain).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ch_addr/rd/wr/din/din_m  per-channel request bundles (channel i at slice i)
//   ch_ack/dst/rdy           per-channel handshakes routed from the bank
//   lock, err_clr            channel lockout enable, timeout flag clear
//   ba_*                     bank 0 port of the SDRAM controller
//   owner, busy, tout_err    grant index, transaction active, sticky timeouts
module jtframe_sdram_arb #(
   parameter int unsigned AW       = 22,
   parameter int unsigned CH       = 4,
   parameter int unsigned RR       = 0,
   parameter int unsigned TOUT     = 255,
   parameter logic [7:0]  LOCKMASK = 8'h00
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [CH*AW-1:0]   ch_addr,
   input  logic [CH-1:0]      ch_rd,
   input  logic [CH-1:0]      ch_wr,
   input  logic [CH*16-1:0]   ch_din,
   input  logic [CH*2-1:0]    ch_din_m,
   output logic [CH-1:0]      ch_ack,
   output logic [CH-1:0]      ch_dst,
   output logic [CH-1:0]      ch_rdy,
   input  logic               lock,
   input  logic               err_clr,
   output logic [AW-1:0]      ba_addr,
   output logic               ba_rd,
   output logic               ba_wr,
   output logic [15:0]        ba_din,
   output logic [1:0]         ba_din_m,
   input  logic               ba_ack,
   input  logic               ba_dst,
   input  logic               ba_rdy,
   output logic [2:0]         owner,
   output logic               busy,
   output logic [CH-1:0]      tout_err
);

   localparam int unsigned WW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [2:0]    owner_q, owner_d;
   logic [2:0]    rr_q, rr_d;
   logic [WW-1:0] wd_q, wd_d;
   logic [CH-1:0] tout_err_q, tout_err_d;

   logic [CH-1:0] req;
   logic [2:0]    win_fix, win_hi, win_lo, win_rr, win;
   logic          hit_hi;
   logic          act;
   logic [AW-1:0] sel_addr;
   logic [15:0]   sel_din;
   logic [1:0]    sel_dinm;
   logic          sel_rd, sel_wr;

   // Masked request vector; lock only gates new grants
   always_comb begin
      req = '0;
      for (int i = 0; i < int'(CH); i++) begin
         req[i] = (ch_rd[i] | ch_wr[i]) & ~(lock & LOCKMASK[i]);
      end
   end

   // Winner search: lowest index overall, and lowest index after the rr pointer
   always_comb begin
      win_fix = '0;
      win_hi  = '0;
      win_lo  = '0;
      hit_hi  = 1'b0;
      for (int i = int'(CH) - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_fix = 3'(i);
            if (3'(i) > rr_q) begin
               win_hi = 3'(i);
               hit_hi = 1'b1;
            end else begin
               win_lo = 3'(i);
            end
         end
      end
      // Nothing above the pointer wraps around to the lowest at/below it
      win_rr = hit_hi ? win_hi : win_lo;
      win    = (RR != 0) ? win_rr : win_fix;
   end

   // Owner data mux; stays on the last owner while idle
   always_comb begin
      sel_addr = '0;
      sel_din  = '0;
      sel_dinm = '0;
      sel_rd   = 1'b0;
      sel_wr   = 1'b0;
      for (int i = 0; i < int'(CH); i++) begin
         if (owner_q == 3'(i)) begin
            sel_addr = ch_addr[i*AW +: AW];
            sel_din  = ch_din[i*16 +: 16];
            sel_dinm = ch_din_m[i*2 +: 2];
            sel_rd   = ch_rd[i];
            sel_wr   = ch_wr[i];
         end
      end
   end

   // A reset cycle already drops the grant so late bank strobes go nowhere
   assign act      = (state_q == BUSY) & ~rst;
   assign ba_addr  = sel_addr;
   assign ba_din   = sel_din;
   assign ba_din_m = sel_dinm;
   assign ba_rd    = act & sel_rd;
   assign ba_wr    = act & sel_wr;

   // Bank handshakes go back to the owner only
   always_comb begin
      ch_ack = '0;
      ch_dst = '0;
      ch_rdy = '0;
      for (int i = 0; i < int'(CH); i++) begin
         if (act && owner_q == 3'(i)) begin
            ch_ack[i] = ba_ack;
            ch_dst[i] = ba_dst;
            ch_rdy[i] = ba_rdy;
         end
      end
   end

   // Grant / release / watchdog next-state logic
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_d       = rr_q;
      wd_d       = wd_q;
      tout_err_d = err_clr ? '0 : tout_err_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = BUSY;
               owner_d = win;
               rr_d    = win;
               wd_d    = '0;
            end
         end
         BUSY: begin
            if (ba_rdy) begin
               state_d = IDLE;
            end else if (TOUT != 0 && wd_q == WW'(TOUT - 1)) begin
               // Expiry frees the bank; ba_rdy on this cycle took the branch above
               state_d = IDLE;
               for (int i = 0; i < int'(CH); i++) begin
                  if (owner_q == 3'(i)) tout_err_d[i] = 1'b1;
               end
            end else if (wd_q != WW'(TOUT)) begin
               wd_d = wd_q + WW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         rr_q       <= 3'(CH - 1);
         wd_q       <= '0;
         tout_err_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_q       <= rr_d;
         wd_q       <= wd_d;
         tout_err_q <= tout_err_d;
      end
   end

   assign owner    = owner_q;
   assign busy     = (state_q == BUSY);
   assign tout_err = tout_err_q;

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Bench for jtframe_sdram_arb: a fixed-priority and a round-robin instance
// share all master-side stimulus; each has its own bank responder.
module tb_jtframe_sdram_arb;
   localparam int AW   = 22;
   localparam int CH   = 4;
   localparam int TOUT = 16;
   localparam logic [CH-1:0] LM = 4'b0100;

   logic clk = 1'b0;
   logic rst;
   logic [CH*AW-1:0] ch_addr;
   logic [CH-1:0]    ch_rd, ch_wr;
   logic [CH*16-1:0] ch_din;
   logic [CH*2-1:0]  ch_din_m;
   logic             lock, err_clr;
   logic             r_ack[2], r_dst[2], r_rdy[2];

   logic [CH-1:0] o_ack[2], o_dst[2], o_rdy[2], o_err[2];
   logic [AW-1:0] o_addr[2];
   logic          o_rd[2], o_wr[2], o_busy[2];
   logic [15:0]   o_din[2];
   logic [1:0]    o_dinm[2];
   logic [2:0]    o_own[2];

   always #5 clk = ~clk;

   jtframe_sdram_arb #(.AW(AW), .CH(CH), .RR(0), .TOUT(TOUT), .LOCKMASK(8'(LM))) dut_f (
      .clk(clk), .rst(rst), .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr),
      .ch_din(ch_din), .ch_din_m(ch_din_m), .ch_ack(o_ack[0]), .ch_dst(o_dst[0]),
      .ch_rdy(o_rdy[0]), .lock(lock), .err_clr(err_clr), .ba_addr(o_addr[0]),
      .ba_rd(o_rd[0]), .ba_wr(o_wr[0]), .ba_din(o_din[0]), .ba_din_m(o_dinm[0]),
      .ba_ack(r_ack[0]), .ba_dst(r_dst[0]), .ba_rdy(r_rdy[0]), .owner(o_own[0]),
      .busy(o_busy[0]), .tout_err(o_err[0]));

   jtframe_sdram_arb #(.AW(AW), .CH(CH), .RR(1), .TOUT(TOUT), .LOCKMASK(8'(LM))) dut_r (
      .clk(clk), .rst(rst), .ch_addr(ch_addr), .ch_rd(ch_rd), .ch_wr(ch_wr),
      .ch_din(ch_din), .ch_din_m(ch_din_m), .ch_ack(o_ack[1]), .ch_dst(o_dst[1]),
      .ch_rdy(o_rdy[1]), .lock(lock), .err_clr(err_clr), .ba_addr(o_addr[1]),
      .ba_rd(o_rd[1]), .ba_wr(o_wr[1]), .ba_din(o_din[1]), .ba_din_m(o_dinm[1]),
      .ba_ack(r_ack[1]), .ba_dst(r_dst[1]), .ba_rdy(r_rdy[1]), .owner(o_own[1]),
      .busy(o_busy[1]), .tout_err(o_err[1]));

   int checks = 0;
   int errors = 0;

   // Reference model: index 0 = fixed priority, 1 = round robin
   int            m_busy[2], m_own[2], m_cnt[2], m_ptr[2];
   logic [CH-1:0] m_err[2];

   // Responder controls
   int rmode, ack_at, rdy_at, rdy_mod;
   bit rdy_en, dst_force;

   int  gq0[$], gq1[$];
   int  saw_rdy1[2];
   bit  prev_busy[2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_resp();
      for (int m = 0; m < 2; m++) begin
         if (rmode != 0) begin
            r_ack[m] = ($urandom % 3) == 0;
            r_dst[m] = ($urandom % 3) == 0;
            r_rdy[m] = ($urandom % rdy_mod) == 0;
         end else begin
            r_ack[m] = (m_busy[m] != 0) && (m_cnt[m] == ack_at);
            r_dst[m] = (m_busy[m] != 0) && (m_cnt[m] == rdy_at);
            r_rdy[m] = rdy_en && (m_busy[m] != 0) && (m_cnt[m] == rdy_at);
         end
         r_dst[m] = r_dst[m] | dst_force;
      end
   endtask

   task automatic check_cycle();
      logic act;
      int o;
      logic [CH-1:0] oh;
      for (int m = 0; m < 2; m++) begin
         act = (m_busy[m] != 0) && !rst;
         o   = m_own[m];
         oh  = CH'(1) << o;
         chk($sformatf("d%0d_busy", m),  64'(o_busy[m]), 64'(m_busy[m]));
         chk($sformatf("d%0d_owner", m), 64'(o_own[m]),  64'(o));
         chk($sformatf("d%0d_terr", m),  64'(o_err[m]),  64'(m_err[m]));
         chk($sformatf("d%0d_ba_rd", m), 64'(o_rd[m]),   64'(act & 1'(ch_rd >> o)));
         chk($sformatf("d%0d_ba_wr", m), 64'(o_wr[m]),   64'(act & 1'(ch_wr >> o)));
         chk($sformatf("d%0d_addr", m),  64'(o_addr[m]), 64'(AW'(ch_addr >> (o*AW))));
         chk($sformatf("d%0d_din", m),   64'(o_din[m]),  64'(16'(ch_din >> (o*16))));
         chk($sformatf("d%0d_dinm", m),  64'(o_dinm[m]), 64'(2'(ch_din_m >> (o*2))));
         chk($sformatf("d%0d_ack", m),   64'(o_ack[m]),  64'((act && r_ack[m]) ? oh : CH'(0)));
         chk($sformatf("d%0d_dst", m),   64'(o_dst[m]),  64'((act && r_dst[m]) ? oh : CH'(0)));
         chk($sformatf("d%0d_rdy", m),   64'(o_rdy[m]),  64'((act && r_rdy[m]) ? oh : CH'(0)));
         if (o_rdy[m][1]) saw_rdy1[m]++;
         if (o_busy[m] && !prev_busy[m]) begin
            if (m == 0) gq0.push_back(int'(o_own[m]));
            else        gq1.push_back(int'(o_own[m]));
         end
         prev_busy[m] = o_busy[m];
      end
   endtask

   task automatic model_update();
      logic [CH-1:0] req, e;
      int w, idx;
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            m_busy[m] = 0; m_own[m] = 0; m_ptr[m] = CH-1; m_cnt[m] = 0; m_err[m] = '0;
         end else begin
            e = err_clr ? '0 : m_err[m];
            if (m_busy[m] == 0) begin
               req = (ch_rd | ch_wr) & ~({CH{lock}} & LM);
               if (req != 0) begin
                  w = -1;
                  for (int k = 0; k < CH; k++) begin
                     idx = (m == 1) ? (m_ptr[m] + 1 + k) % CH : k;
                     if (w < 0 && 1'(req >> idx)) w = idx;
                  end
                  m_own[m] = w; m_ptr[m] = w; m_busy[m] = 1; m_cnt[m] = 0;
               end
            end else if (r_rdy[m]) begin
               m_busy[m] = 0;
            end else if (m_cnt[m] == TOUT-1) begin
               m_busy[m] = 0;
               e = e | (CH'(1) << m_own[m]);
            end else begin
               m_cnt[m]++;
            end
            m_err[m] = e;
         end
      end
   endtask

   // One clock: drive bank strobes, check settled outputs, advance the model
   task automatic step();
      drive_resp();
      #1;
      check_cycle();
      model_update();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int exp_rr[5];
      exp_rr = '{0, 1, 2, 3, 0};
      rst = 1'b1; ch_rd = '0; ch_wr = '0; lock = 1'b0; err_clr = 1'b0;
      ch_addr = (CH*AW)'({$urandom(), $urandom(), $urandom()});
      ch_din = {$urandom(), $urandom()}; ch_din_m = 8'($urandom());
      rmode = 0; rdy_en = 1'b1; ack_at = 2; rdy_at = 7; rdy_mod = 5; dst_force = 1'b0;
      for (int m = 0; m < 2; m++) begin
         m_busy[m] = 0; m_own[m] = 0; m_ptr[m] = CH-1; m_cnt[m] = 0; m_err[m] = '0;
         r_ack[m] = 1'b0; r_dst[m] = 1'b0; r_rdy[m] = 1'b0; prev_busy[m] = 1'b0;
      end
      @(negedge clk); @(posedge clk); @(negedge clk);
      do_reset();

      // Fixed priority with channels 1 and 3 held: channel 1 keeps winning
      gq0.delete(); gq1.delete();
      ch_rd = 4'b1010;
      repeat (40) step();
      ch_rd = '0;
      chk("fix_ngrants", 64'(gq0.size() >= 3), 64'(1));
      foreach (gq0[i]) chk($sformatf("fix_grant%0d", i), 64'(gq0[i]), 64'(1));

      // Round robin with all channels requesting
      do_reset();
      gq0.delete(); gq1.delete();
      ch_rd = 4'b1111;
      repeat (50) step();
      ch_rd = '0;
      chk("rr_ngrants", 64'(gq1.size() >= 5), 64'(1));
      for (int i = 0; i < 5 && i < gq1.size(); i++)
         chk($sformatf("rr_grant%0d", i), 64'(gq1[i]), 64'(exp_rr[i]));

      // Locked channel 2 write, then release
      do_reset();
      ch_wr = 4'b0100; lock = 1'b1;
      ch_din = {$urandom(), $urandom()}; ch_din_m = 8'($urandom());
      repeat (6) step();
      chk("lock_busy", 64'(o_busy[0]), 64'(0));
      chk("lock_wr", 64'(o_wr[0]), 64'(0));
      lock = 1'b0;
      step();
      chk("unlock_owner", 64'(o_own[0]), 64'(2));
      chk("unlock_wr", 64'(o_wr[0]), 64'(1));
      chk("unlock_din", 64'(o_din[0]), 64'(ch_din[47:32]));
      chk("unlock_dinm", 64'(o_dinm[0]), 64'(ch_din_m[5:4]));
      repeat (10) step();
      ch_wr = '0;

      // Watchdog expiry on channel 1
      do_reset();
      rdy_en = 1'b0; saw_rdy1[0] = 0; saw_rdy1[1] = 0;
      ch_rd = 4'b0010;
      repeat (17) step();
      ch_rd = '0;
      repeat (3) step();
      chk("wd_err_f", 64'(o_err[0]), 64'(4'b0010));
      chk("wd_err_r", 64'(o_err[1]), 64'(4'b0010));
      chk("wd_no_rdy", 64'(saw_rdy1[0]), 64'(0));
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("wd_clr", 64'(o_err[0]), 64'(0));
      step();

      // ba_rdy exactly on the expiry cycle
      do_reset();
      rdy_en = 1'b1; rdy_at = 15; saw_rdy1[0] = 0;
      ch_rd = 4'b0010;
      repeat (17) step();
      ch_rd = '0;
      repeat (3) step();
      chk("exp_rdy_seen", 64'(saw_rdy1[0]), 64'(1));
      chk("exp_no_err", 64'(o_err[0]), 64'(0));
      rdy_at = 7;

      // Reset mid-transaction with ba_dst pending
      do_reset();
      ch_rd = 4'b0100;
      step(); step();
      ch_rd = 4'b0010; dst_force = 1'b1; rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_busy", 64'(o_busy[0]), 64'(0));
      chk("rst_owner", 64'(o_own[0]), 64'(0));
      chk("rst_dst", 64'(o_dst[0]), 64'(0));
      step();
      dst_force = 1'b0;
      chk("rst_regrant_busy", 64'(o_busy[0]), 64'(1));
      chk("rst_regrant_owner", 64'(o_own[0]), 64'(1));
      ch_rd = '0;

      // Randomized traffic against the model
      do_reset();
      rmode = 1;
      for (int n = 0; n < 400; n++) begin
         rdy_mod = (n < 200) ? 5 : 24;
         ch_rd   = CH'($urandom());
         ch_wr   = CH'($urandom()) & CH'($urandom());
         lock    = ($urandom % 4) == 0;
         err_clr = ($urandom % 16) == 0;
         rst     = ($urandom % 64) == 0;
         if (($urandom % 4) == 0) begin
            ch_addr  = (CH*AW)'({$urandom(), $urandom(), $urandom()});
            ch_din   = {$urandom(), $urandom()};
            ch_din_m = 8'($urandom());
         end
         step();
      end
      rst = 1'b0; rmode = 0; ch_rd = '0; ch_wr = '0; lock = 1'b0; err_clr = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jtframe_sdram_arb.md
Name: jtframe_sdram_arb

Overview:
- Parametrised N-channel arbiter in front of one SDRAM bank port.
- Generalises the two-way game/PicoBlaze sharing to CH requesters, with selectable fixed-priority or round-robin mode.
- Adds per-channel lockout and a transaction watchdog that frees the bank if ba_rdy never arrives.
- Sits between game/cheat/debug masters and the bank 0 interface of the SDRAM controller, in the clk_rom domain.

Parameters:
- AW, 22, SDRAM word address width.
- CH, 4, number of requesting channels (2..8); channel 0 is the game.
- RR, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- TOUT, 255, watchdog limit in clk cycles per transaction; 0 disables the watchdog.
- LOCKMASK, 0, bit i set means channel i is blocked while lock=1.

Ports:
- clk  in  1  clk_rom.
- rst  in  1  synchronous, active-high.
- ch_addr  in  CH*AW  channel i address at [i*AW +: AW].
- ch_rd  in  CH  read request per channel, held until ack.
- ch_wr  in  CH  write request per channel, held until ack.
- ch_din  in  CH*16  write data per channel.
- ch_din_m  in  CH*2  write byte mask per channel.
- ch_ack  out  CH  routed ba_ack.
- ch_dst  out  CH  routed ba_dst.
- ch_rdy  out  CH  routed ba_rdy.
- lock  in  1  applies LOCKMASK.
- err_clr  in  1  clears timeout flags.
- ba_addr  out  AW  address to SDRAM.
- ba_rd  out  1  read to SDRAM.
- ba_wr  out  1  write to SDRAM.
- ba_din  out  16  write data to SDRAM.
- ba_din_m  out  2  write mask to SDRAM.
- ba_ack  in  1  from SDRAM.
- ba_dst  in  1  from SDRAM.
- ba_rdy  in  1  from SDRAM.
- owner  out  3  current grant index.
- busy  out  1  high in BUSY.
- tout_err  out  CH  sticky per-channel timeout flag.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - On reset: state=IDLE, owner=0, rr pointer=CH-1, watchdog=0, tout_err=0, busy=0.
  - Reset mid-transaction abandons the grant immediately; late ba_ack/ba_dst/ba_rdy is not routed anywhere.
- Request vector:
  - req[i] = (ch_rd[i]|ch_wr[i]) & ~(lock & LOCKMASK[i]).
- IDLE:
  - ba_rd=ba_wr=0; ch_ack/ch_dst/ch_rdy=0.
  - If req!=0, register the winner into owner and go to BUSY next cycle.
  - Fixed mode: lowest set index wins.
  - RR mode: search starts at pointer+1 modulo CH; the pointer is loaded with the winner on each grant.
  - Latency: request at cycle n gives ba_rd/ba_wr at cycle n+1.
- BUSY:
  - ba_addr/ba_din/ba_din_m come from channel owner.
  - ba_rd = ch_rd[owner]; ba_wr = ch_wr[owner]. A request dropped by the master is forwarded as 0 and the grant is kept.
  - Lock is not applied to an already granted transaction.
  - ch_ack[owner]=ba_ack, ch_dst[owner]=ba_dst, ch_rdy[owner]=ba_rdy, all combinational; other channels see 0.
  - On ba_rdy, go to IDLE. There is one dead IDLE cycle before the next grant.
- Outputs in IDLE:
  - ba_addr/ba_din/ba_din_m keep showing the last owner's values. Only ba_rd/ba_wr are forced to 0.
- Watchdog:
  - Counter is cleared on entry to BUSY and increments each BUSY cycle.
  - If TOUT!=0 and the counter reaches TOUT-1 with no ba_rdy: go to IDLE, set tout_err[owner], generate no ch_rdy.
  - ba_rdy in the same cycle as expiry: ba_rdy wins and no error is set.
  - Counter width is ceil(log2(TOUT+1)). It saturates and never wraps.
- tout_err:
  - Cleared by rst or err_clr.
  - A set in the same cycle as err_clr wins.
- Routing outside BUSY:
  - ba_ack/ba_dst/ba_rdy arriving in IDLE are ignored.
- Status outputs:
  - busy = (state==BUSY).
  - owner is zero-extended to 3 bits.

Test Plan:
- Fixed mode, CH=4, ch_rd=4'b1010 held, each ack after 3 cycles and rdy after 8 -> grants are 1, 1, 1 (channel 3 starves); ba_addr equals ch_addr[1].
- RR=1, all four channels requesting continuously -> grant order 0,1,2,3,0; exactly one idle cycle between each ba_rdy and the next ba_rd.
- lock=1, LOCKMASK=4'b0100, only ch_wr[2] asserted -> no grant and ba_wr stays 0. Release lock -> grant 2 next cycle, and ba_din/ba_din_m match channel 2.
- TOUT=16, grant channel 1, ba_rdy never asserted -> IDLE after 16 BUSY cycles, tout_err=4'b0010, ch_rdy[1] never high. err_clr -> tout_err=0.
- ba_rdy asserted exactly on the expiry cycle -> ch_rdy[owner]=1 and tout_err stays 0.
- rst asserted while BUSY with ba_dst pending -> next cycle: busy=0, owner=0, no ch_dst pulse, and a new request is granted normally.
